gray_tracker: RTL and testbench
===============================

# gray_tracker

Downstream consumer of the Gray-code counter output. Synchronises an N-bit Gray code into the local `clk` domain and decodes it to binary. Classifies every sample-to-sample change as hold, single step up, single step down or illegal jump. Provides registered position, direction pulses, wrap indication and error statistics to the control logic behind it.

## Interface

- `N`, 4: Gray/binary word width (≥2).
- `SYNC_STAGES`, 2: synchroniser flops on `gray_in` (≥2).
- `ERR_CNT_W`, 8: error counter width.

Ports:

- `clk` input 1: single clock, all flops rising-edge.
- `rstn` input 1: reset, **asynchronous, active-low**. Asserts immediately; released synchronously by the integrating design.
- `gray_in` input N: Gray code from the upstream counter; may be asynchronous to `clk`.
- `clr_err` input 1: synchronous pulse; clears `err_cnt`.
- `bin_out` output N: registered binary position.
- `bin_valid` output 1: `bin_out` is tracked and trusted.
- `step_up` output 1: one-cycle pulse, position advanced by +1 (mod 2^N).
- `step_dn` output 1: one-cycle pulse, position moved by −1 (mod 2^N).
- `wrap` output 1: one-cycle pulse, coincident with a step that crosses 2^N−1 ↔ 0.
- `err` output 1: one-cycle pulse on an illegal jump.
- `err_cnt` output ERR_CNT_W: saturating illegal-jump count.

## Operation

- Synchroniser: `gray_in` passes through `SYNC_STAGES` flops; the last stage is `g_s`.
- Decode (combinational): `b[N-1]=g_s[N-1]`, `b[i]=b[i+1]^g_s[i]`.
- `bin_out <= b` every cycle out of reset, in all states.
- Classification uses the difference `d = b − bin_out`, computed modulo 2^N in N bits:
  - `d==0`: hold, no flags.
  - `d==1`: `step_up`. Also `wrap` if `bin_out==2^N−1`.
  - `d==2^N−1`: `step_dn`. Also `wrap` if `bin_out==0`.
  - Otherwise: illegal. `err` pulses and `err_cnt` increments unless it is at all-ones.
- FSM, three states:
  - ACQ, entered on reset. Counts `SYNC_STAGES+1` cycles to flush the synchroniser. All flags are suppressed and `bin_valid=0`. Goes to TRACK.
  - TRACK. `bin_valid=1` and flags are active. An illegal jump goes to RESYNC.
  - RESYNC, lasts exactly one cycle. `bin_valid=0` and flags are suppressed. Goes to TRACK.
  - An illegal jump detected in TRACK is flagged in that same cycle; `bin_out` takes the new value regardless.
- `clr_err` together with an illegal jump in the same cycle: `err_cnt` becomes 1. Clear, then count.
- Reset mid-operation returns to ACQ at once. All outputs take their reset values asynchronously.

## Timing

- Reset values:
  - `bin_out=0`, `bin_valid=0`, `err_cnt=0`.
  - `step_up`, `step_dn`, `wrap` and `err` all 0.
  - Synchroniser flops 0.
  - FSM in ACQ.
- Latency: a `gray_in` change appears on `bin_out` `SYNC_STAGES+1` clocks later. Flags are asserted in the same cycle that `bin_out` shows the new value.
- First `bin_valid=1`: cycle `SYNC_STAGES+2` after `rstn` release (cycle 4 with default parameters).
- All flag outputs are registered, one cycle wide and mutually exclusive, except that `wrap` accompanies a step.
- Back-to-back steps on consecutive cycles each produce their own pulse.

## Configuration

- `GRAY_TRACKER_STATS_EN` defined:
  - The `err_cnt` register and the `clr_err` logic are built.
- Not defined:
  - `err_cnt` is tied to 0 and `clr_err` is ignored.
  - The `err` pulse and RESYNC behaviour are unchanged.
  - Port list is identical in both builds.

## Structure

- Package `gray_pkg`:
  - State enum `gt_state_t` {ACQ, TRACK, RESYNC}.
  - Function `gray2bin` (parameterised by width).
  - Localparam for the minimum legal `SYNC_STAGES`.
  - `gray2bin` is shared with other Gray-code consumers in the design.
- Sub-module `gray_sync`: parameterised N-bit, `SYNC_STAGES`-deep synchroniser with async active-low reset. It is instantiated once.
- Top module holds the decode, classifier, FSM, flag registers and counter.

## Test plan

- Reset, then hold `gray_in=0000`:
  - `bin_valid` rises at cycle 4.
  - `bin_out=0` and no flags.
- Drive the Gray sequence 0000, 0001, 0011, 0010, 0110, one per cycle:
  - `bin_out` shows 1, 2, 3, 4 at 3-cycle latency.
  - One `step_up` per value.
  - No `err`.
- Gray 1000 → 0000 (bin 15 → 0):
  - `step_up` and `wrap` asserted together.
  - Reverse direction 0000 → 1000 gives `step_dn` and `wrap`.
- Gray 0001 → 0110 (bin 1 → 4):
  - `err` pulses and `err_cnt=1`.
  - `bin_valid` low for exactly one cycle, then `bin_out=4` tracked.
- With the stats macro defined, force 300 illegal jumps:
  - `err_cnt` saturates at 255.
  - `clr_err` coinciding with a further jump gives `err_cnt=1`.
  - Without the macro, `err_cnt` stays 0.
- Assert `rstn` low mid-stream while `bin_out=7`:
  - All outputs 0 immediately, with no clock edge needed.
  - After release, the ACQ sequence repeats.

Source files
------------

// File: rtl/gray_tracker_pkg.sv
// Shared types and the Gray-to-binary decode for every Gray-code consumer.
// gray2bin works on any width up to GRAY_MAX_W: zero-extend the code, then truncate the result.
package gray_pkg;

  localparam int GRAY_MIN_SYNC_STAGES = 2;
  localparam int GRAY_MAX_W           = 32;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } gt_state_t;

  typedef enum logic [1:0] {
    MOVE_HOLD    = 2'd0,
    MOVE_UP      = 2'd1,
    MOVE_DN      = 2'd2,
    MOVE_ILLEGAL = 2'd3
  } gt_move_t;

  // Leading zeros in the Gray code stay zeros in the binary result.
  // Narrower words therefore decode correctly through the full-width loop.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_tracker_sync.sv
// Multi-flop synchroniser for an N-bit Gray word arriving from another clock domain.
// Only one bit changes per legal step, so the captured word is always an old or a new value.
module gray_sync
  import gray_pkg::*;
#(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  localparam int DEPTH = (STAGES < GRAY_MIN_SYNC_STAGES) ? GRAY_MIN_SYNC_STAGES : STAGES;

  logic [W-1:0] stage [DEPTH];

  // NOTE: every stage is reset, not only the output flop. After reset release the
  // classifier must never see a leftover pre-reset value walking out of the chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage take its neighbour's old value,
      // so the chain shifts by one flop per clock.
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/gray_tracker.sv
// Tracks a synchronised Gray position and reports steps, wraps and illegal jumps.
// Define GRAY_TRACKER_STATS_EN to build err_cnt and clr_err; otherwise err_cnt is tied to 0.
module gray_tracker
  import gray_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         gray_in,
  input  logic                 clr_err,
  output logic [N-1:0]         bin_out,
  output logic                 bin_valid,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 wrap,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int SYNC_D = (SYNC_STAGES < GRAY_MIN_SYNC_STAGES) ? GRAY_MIN_SYNC_STAGES
                                                               : SYNC_STAGES;
  localparam int CNT_W  = $clog2(SYNC_D + 2);
  // ACQ is left on the edge after the synchroniser and bin_out are fully flushed.
  localparam logic [CNT_W-1:0] ACQ_LAST = CNT_W'(SYNC_D + 1);

  gt_state_t        state;
  logic [CNT_W-1:0] acq_cnt;
  logic [N-1:0]     g_s;
  logic [N-1:0]     b;
  logic [N-1:0]     delta;
  gt_move_t         move;
  logic             jump_err;

  gray_sync #(
    .W      (N),
    .STAGES (SYNC_D)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (gray_in),
    .q    (g_s)
  );

  assign b     = N'(gray2bin(GRAY_MAX_W'(g_s)));
  assign delta = b - bin_out;

  // NOTE: move gets a default before the decision chain, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    move = MOVE_ILLEGAL;
    if (delta == '0) begin
      move = MOVE_HOLD;
    end else if (delta == N'(1)) begin
      move = MOVE_UP;
    end else if (delta == '1) begin
      move = MOVE_DN;
    end
  end

  assign jump_err = (state == TRACK) && (move == MOVE_ILLEGAL);

  // bin_valid is written with the state being entered, so it is high exactly while in TRACK.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ACQ;
      acq_cnt   <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      bin_out <= b;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
      case (state)
        ACQ: begin
          if (acq_cnt == ACQ_LAST) begin
            state     <= TRACK;
            acq_cnt   <= '0;
            bin_valid <= 1'b1;
          end else begin
            acq_cnt <= acq_cnt + CNT_W'(1);
          end
        end
        TRACK: begin
          step_up <= (move == MOVE_UP);
          step_dn <= (move == MOVE_DN);
          wrap    <= ((move == MOVE_UP) && (bin_out == '1)) ||
                     ((move == MOVE_DN) && (bin_out == '0));
          if (jump_err) begin
            err       <= 1'b1;
            bin_valid <= 1'b0;
            state     <= RESYNC;
          end
        end
        RESYNC: begin
          state     <= TRACK;
          bin_valid <= 1'b1;
        end
        default: begin
          state     <= ACQ;
          acq_cnt   <= '0;
          bin_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef GRAY_TRACKER_STATS_EN
  // A clear in the same cycle as a jump still records that jump.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= jump_err ? ERR_CNT_W'(1) : '0;
    end else if (jump_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_gray_tracker.sv
// Directed scoreboard bench for gray_tracker: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them. Works with and without GRAY_TRACKER_STATS_EN.
module tb_gray_tracker;

`ifdef GRAY_TRACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [3:0] F_UP = 4'b1000;
  localparam logic [3:0] F_DN = 4'b0100;
  localparam logic [3:0] F_WR = 4'b0010;
  localparam logic [3:0] F_ER = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] bin;
    logic       valid;
    logic [3:0] flags;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       step_up;
  logic       step_dn;
  logic       wrap;
  logic       err;
  logic [7:0] err_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb [$];

  gray_tracker dut (
    .clk       (clk),
    .rstn      (rstn),
    .gray_in   (gray_in),
    .clr_err   (clr_err),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .wrap      (wrap),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input int c, input logic [3:0] bin, input logic v,
                      input logic [3:0] f, input logic [7:0] cnt);
    exp_t e;
    e.cyc   = c;
    e.bin   = bin;
    e.valid = v;
    e.flags = f;
    e.cnt   = STATS ? cnt : 8'd0;
    sb.push_back(e);
  endtask

  task automatic go(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " bin_out"},   32'(bin_out),   32'd0);
    check({tag, " bin_valid"}, 32'(bin_valid), 32'd0);
    check({tag, " flags"},     32'({step_up, step_dn, wrap, err}), 32'd0);
    check({tag, " err_cnt"},   32'(err_cnt),   32'd0);
  endtask

  // Monitor: compares the DUT against the queued expectation for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          check($sformatf("c%0d missed", e.cyc), 32'(cyc), 32'(e.cyc));
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          check($sformatf("c%0d bin_out", cyc),   32'(bin_out),   32'(e.bin));
          check($sformatf("c%0d bin_valid", cyc), 32'(bin_valid), 32'(e.valid));
          check($sformatf("c%0d flags", cyc),     32'({step_up, step_dn, wrap, err}), 32'(e.flags));
          check($sformatf("c%0d err_cnt", cyc),   32'(err_cnt),   32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] walk [7];
    walk = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100};
    rstn    = 1'b0;
    gray_in = 4'b0000;
    clr_err = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Acquisition with a steady zero, then four legal up-steps.
    push(1, 4'd0, 1'b0, 4'd0, 8'd0);
    push(2, 4'd0, 1'b0, 4'd0, 8'd0);
    push(3, 4'd0, 1'b0, 4'd0, 8'd0);
    push(4, 4'd0, 1'b1, 4'd0, 8'd0);
    push(5, 4'd0, 1'b1, 4'd0, 8'd0);
    push(8, 4'd0, 1'b1, 4'd0, 8'd0);
    push(9,  4'd1, 1'b1, F_UP, 8'd0);
    push(10, 4'd2, 1'b1, F_UP, 8'd0);
    push(11, 4'd3, 1'b1, F_UP, 8'd0);
    push(12, 4'd4, 1'b1, F_UP, 8'd0);
    push(13, 4'd4, 1'b1, 4'd0, 8'd0);
    go(6); gray_in = 4'b0001;
    go(7); gray_in = 4'b0011;
    go(8); gray_in = 4'b0010;
    go(9); gray_in = 4'b0110;

    // Jump to 15, then wrap up to 0 and back down to 15.
    push(16, 4'd4,  1'b1, 4'd0,        8'd0);
    push(17, 4'd15, 1'b0, F_ER,        8'd1);
    push(18, 4'd15, 1'b1, 4'd0,        8'd1);
    push(21, 4'd15, 1'b1, 4'd0,        8'd1);
    push(22, 4'd0,  1'b1, F_UP | F_WR, 8'd1);
    push(23, 4'd0,  1'b1, 4'd0,        8'd1);
    push(27, 4'd15, 1'b1, F_DN | F_WR, 8'd1);
    push(28, 4'd15, 1'b1, 4'd0,        8'd1);
    go(14); gray_in = 4'b1000;
    go(19); gray_in = 4'b0000;
    go(24); gray_in = 4'b1000;

    // Illegal 15->1, clear, illegal 1->4, two back-to-back down-steps, illegal 2->7.
    push(31, 4'd15, 1'b1, 4'd0, 8'd1);
    push(32, 4'd1,  1'b0, F_ER, 8'd2);
    push(33, 4'd1,  1'b1, 4'd0, 8'd2);
    push(34, 4'd1,  1'b1, 4'd0, 8'd0);
    push(37, 4'd4,  1'b0, F_ER, 8'd1);
    push(38, 4'd4,  1'b1, 4'd0, 8'd1);
    push(42, 4'd3,  1'b1, F_DN, 8'd1);
    push(43, 4'd2,  1'b1, F_DN, 8'd1);
    push(44, 4'd2,  1'b1, 4'd0, 8'd1);
    push(47, 4'd7,  1'b0, F_ER, 8'd2);
    push(48, 4'd7,  1'b1, 4'd0, 8'd2);
    go(29); gray_in = 4'b0001;
    go(33); clr_err = 1'b1;
    go(34); clr_err = 1'b0; gray_in = 4'b0110;
    go(39); gray_in = 4'b0010;
    go(40); gray_in = 4'b0011;
    go(44); gray_in = 4'b0100;

    // 300 illegal jumps between 7 and 0, one every two cycles; the count saturates.
    push(53,  4'd0, 1'b0, F_ER, 8'd3);
    push(54,  4'd0, 1'b1, 4'd0, 8'd3);
    push(555, 4'd7, 1'b0, F_ER, 8'd254);
    push(556, 4'd7, 1'b1, 4'd0, 8'd254);
    push(557, 4'd0, 1'b0, F_ER, 8'd255);
    push(651, 4'd7, 1'b0, F_ER, 8'd255);
    push(652, 4'd7, 1'b1, 4'd0, 8'd255);
    for (int j = 0; j < 300; j++) begin
      go(50 + 2 * j);
      gray_in = (j % 2 == 0) ? 4'b0000 : 4'b0100;
    end

    // Clear coinciding with a jump, then a legal walk from 0 up to 7.
    push(656, 4'd0, 1'b0, F_ER, 8'd1);
    push(657, 4'd0, 1'b1, 4'd0, 8'd1);
    for (int k = 0; k < 7; k++) begin
      push(661 + k, 4'(k + 1), 1'b1, F_UP, 8'd1);
    end
    push(668, 4'd7, 1'b1, 4'd0, 8'd1);
    go(653); gray_in = 4'b0000;
    go(655); clr_err = 1'b1;
    go(656); clr_err = 1'b0;
    for (int k = 0; k < 7; k++) begin
      go(658 + k);
      gray_in = walk[k];
    end

    // Reset mid-cycle while bin_out=7: outputs clear with no clock edge.
    go(668);
    #2 rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset queue", 32'(sb.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    push(1, 4'd0, 1'b0, 4'd0, 8'd0);
    push(2, 4'd0, 1'b0, 4'd0, 8'd0);
    push(3, 4'd7, 1'b0, 4'd0, 8'd0);
    push(4, 4'd7, 1'b1, 4'd0, 8'd0);
    push(5, 4'd7, 1'b1, 4'd0, 8'd0);
    go(7);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
